fitbit_metric_sequencer: RTL

- Parametrised display sequencer for the fitness tracker. It replaces the fixed four-metric, two-second rotation in the top level.
- Takes N_CH packed metric channels and rotates the displayed channel every DWELL_SEC second ticks.
- Supports a per-channel enable mask, hold, manual next, restart on start, and saturation flagging with clamping.
- Its outputs drive the seven-segment display driver: value, alternate-format flag and channel index.

---
 rtl/fitbit_metric_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fitbit_metric_sequencer.sv
// Rotating metric display sequencer: cycles enabled channels every DWELL_SEC ticks, clamps and flags saturation.
// Optional FITSEQ_SNAPSHOT_EN: latch disp_value_o on channel entry instead of tracking the live metric.
module fitbit_metric_sequencer #(
  parameter int              N_CH      = 4,
  parameter int              W         = 16,
  parameter int              DWELL_SEC = 2,
  parameter int              SAT_LIMIT = 9999,
  parameter logic [N_CH-1:0] ALT_MASK  = N_CH'(4'b0010)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     sec_tick_i,
  input  logic                     hold_i,
  input  logic                     next_i,
  input  logic [N_CH-1:0]          ch_en_i,
  input  logic [N_CH*W-1:0]        metrics_i,
  output logic [$clog2(N_CH)-1:0]  disp_ch_o,
  output logic [W-1:0]             disp_value_o,
  output logic                     disp_alt_o,
  output logic [N_CH-1:0]          sat_flags_o,
  output logic                     sat_o
);

  localparam int              CW         = $clog2(N_CH);
  localparam int              DW         = (DWELL_SEC > 1) ? $clog2(DWELL_SEC) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_SEC - 1);
  localparam logic [W-1:0]    SAT_W      = W'(SAT_LIMIT);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_OFF} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            start_q, next_q;
  logic [W-1:0]    value_q, value_d;
  logic            alt_q, alt_d;
  logic [N_CH-1:0] sat_flags_q, sat_flags_d;
  logic            sat_q, sat_d;
  logic            start_rise, next_rise, entry;
  logic [W-1:0]    val_live;

  function automatic logic [CW-1:0] lowest_en(input logic [N_CH-1:0] en);
    lowest_en = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en[i]) lowest_en = CW'(i);
    end
  endfunction

  // Upward modulo search; landing back on cur means it is the only enabled channel.
  function automatic logic [CW-1:0] next_en(input logic [CW-1:0] cur, input logic [N_CH-1:0] en);
    logic found;
    int   idx;
    next_en = cur;
    found   = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(cur) + k) % N_CH;
      if (!found && en[idx]) begin
        next_en = CW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [W-1:0] clamp(input logic [W-1:0] m);
    clamp = (m > SAT_W) ? SAT_W : m;
  endfunction

  assign start_rise = start_i & ~start_q;
  assign next_rise  = next_i & ~next_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    entry   = 1'b0;
    if (ch_en_i == '0) begin
      state_d = ST_OFF;
      dwell_d = '0;
    end else begin
      state_d = hold_i ? ST_HOLD : ST_RUN;
      if (state_q == ST_OFF || start_rise) begin
        ch_d    = lowest_en(ch_en_i);
        dwell_d = '0;
        entry   = 1'b1;
      end else if (!ch_en_i[ch_q]) begin
        ch_d    = next_en(ch_q, ch_en_i);
        dwell_d = '0;
        entry   = 1'b1;
      end else if (next_rise) begin
        ch_d    = next_en(ch_q, ch_en_i);
        dwell_d = '0;
        entry   = 1'b1;
      end else if (state_q == ST_RUN && sec_tick_i) begin
        if (dwell_q == DWELL_LAST) begin
          ch_d    = next_en(ch_q, ch_en_i);
          dwell_d = '0;
          entry   = 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sat_flags_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      sat_flags_d[i] = metrics_i[i*W +: W] > SAT_W;
    end
    sat_d    = |(sat_flags_d & ch_en_i);
    val_live = clamp(metrics_i[int'(ch_d)*W +: W]);
    alt_d    = ALT_MASK[ch_d];
  end

`ifdef FITSEQ_SNAPSHOT_EN
  logic first_q;

  // first_q forces a capture on the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) first_q <= 1'b1;
    else         first_q <= 1'b0;
  end

  always_comb begin
    value_d = value_q;
    if (ch_en_i == '0)          value_d = '0;
    else if (entry || first_q)  value_d = val_live;
  end
`else
  always_comb begin
    value_d = (ch_en_i == '0) ? '0 : val_live;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      ch_q        <= '0;
      dwell_q     <= '0;
      start_q     <= 1'b0;
      next_q      <= 1'b0;
      value_q     <= '0;
      alt_q       <= ALT_MASK[0];
      sat_flags_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dwell_q     <= dwell_d;
      start_q     <= start_i;
      next_q      <= next_i;
      value_q     <= value_d;
      alt_q       <= alt_d;
      sat_flags_q <= sat_flags_d;
      sat_q       <= sat_d;
    end
  end

  assign disp_ch_o    = ch_q;
  assign disp_value_o = value_q;
  assign disp_alt_o   = alt_q;
  assign sat_flags_o  = sat_flags_q;
  assign sat_o        = sat_q;

endmodule
